md_issue_ctrl: RTL

//  Pipeline-side initiator for the HI/LO multiply/divide unit. Decodes the E-stage

---
 rtl/md_pkg.sv | 61 ++++++
 rtl/md_busy_counter.sv | 39 +++
 rtl/md_issue_ctrl.sv | 69 ++++++
 3 files changed

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Opcode/funct constants, MD unit op codes and the decode
//                helpers shared by the mult/div issue controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam logic [3:0] MD_OP_NONE  = 4'd0;
    localparam logic [3:0] MD_OP_MULT  = 4'd1;
    localparam logic [3:0] MD_OP_MULTU = 4'd2;
    localparam logic [3:0] MD_OP_DIV   = 4'd3;
    localparam logic [3:0] MD_OP_DIVU  = 4'd4;
    localparam logic [3:0] MD_OP_MTLO  = 4'd5;
    localparam logic [3:0] MD_OP_MTHI  = 4'd6;
    localparam logic [3:0] MD_OP_MFLO  = 4'd7;
    localparam logic [3:0] MD_OP_MFHI  = 4'd8;

    function automatic logic [3:0] md_decode(input logic [31:0] instr);
        logic [3:0] op;
        op = MD_OP_NONE;
        if (instr[31:26] == OPC_SPECIAL) begin
            case (instr[5:0])
                FN_MULT:  op = MD_OP_MULT;
                FN_MULTU: op = MD_OP_MULTU;
                FN_DIV:   op = MD_OP_DIV;
                FN_DIVU:  op = MD_OP_DIVU;
                FN_MTLO:  op = MD_OP_MTLO;
                FN_MTHI:  op = MD_OP_MTHI;
                FN_MFLO:  op = MD_OP_MFLO;
                FN_MFHI:  op = MD_OP_MFHI;
                default:  op = MD_OP_NONE;
            endcase
        end
        return op;
    endfunction

    // Ops that launch a multi-cycle computation in the unit.
    function automatic logic md_is_start(input logic [3:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
               (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_busy_counter.sv
`default_nettype none
// ============================================================================
//  Module      : md_busy_counter
//  Description : Loadable down-counter predicting the MD unit busy window.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_busy_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    // r_busy tracks (r_cnt != 0) one step ahead so busy comes straight off a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (load) begin
            r_cnt  <= load_val;
            r_busy <= (load_val != '0);
        end else begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            r_busy <= (r_cnt > CNT_W'(1));
        end
    end

    assign busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : md_issue_ctrl
//  Description : Issues mult/div ops to the HI/LO unit, predicts its busy
//                window and stalls D-stage MD instructions that would collide.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_instr,
    input  logic [31:0] e_instr,
    input  logic        e_valid,
    input  logic        unit_busy,
    output logic [3:0]  md_op,
    output logic        md_start,
    output logic        stall_d,
    output logic        busy_pred,
    output logic        protocol_err
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [3:0]       w_d_op;
    logic [3:0]       w_e_op;
    logic [CNT_W-1:0] w_load_val;
    logic             w_busy;
    logic             r_err;

    assign w_d_op = md_decode(d_instr);
    assign w_e_op = md_decode(e_instr);

    // A bubble in E must never reach the unit, whatever word the slot holds.
    assign md_op    = e_valid ? w_e_op : MD_OP_NONE;
    assign md_start = e_valid & md_is_start(md_op);

    assign w_load_val = md_is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    md_busy_counter #(
        .CNT_W (CNT_W)
    ) u_busy_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (md_start),
        .load_val (w_load_val),
        .busy     (w_busy)
    );

    assign busy_pred = w_busy;
    assign stall_d   = (w_d_op != MD_OP_NONE) & (md_start | w_busy);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((md_start & w_busy) | (unit_busy != w_busy)) begin
            r_err <= 1'b1;
        end
    end

    assign protocol_err = r_err;

endmodule
`default_nettype wire
